// File: rtl/genius_controle_exibicao.sv
// Purpose: plays the stored Genius colour sequence (addresses 0..limite) on the LEDs, each colour lit then blanked.
// Latency: iniciar at edge k -> CARREGA in cycle k+1; pronto after (limite+1)*(ON+OFF+2) cycles.
// Backpressure: none; iniciar is ignored while ocupado, abortar returns to OCIOSO on the next edge.
//
// Ports: clock/reset (async active-low); iniciar/abortar control; limite latched at start;
//        dado_memoria/endereco talk to the sequence memory; leds_exibicao registered colour output;
//        ocupado/pronto handshake to the main control unit; db_estado exposes the state code.
// Optional feature: define GENIUS_RAPIDO_EN to add the 'rapido' input (halved on/off durations).
module genius_controle_exibicao #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 4,
    parameter int ON_CYCLES  = 500,
    parameter int OFF_CYCLES = 250,
    parameter int CNT_W      = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              abortar,
`ifdef GENIUS_RAPIDO_EN
    input  logic              rapido,
`endif
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] dado_memoria,
    output logic [ADDR_W-1:0] endereco,
    output logic [DATA_W-1:0] leds_exibicao,
    output logic              ocupado,
    output logic              pronto,
    output logic [2:0]        db_estado
);

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        CARREGA = 3'd1,
        ACENDE  = 3'd2,
        APAGA   = 3'd3,
        PROXIMO = 3'd4,
        FIM     = 3'd5
    } estado_t;

    // Terminal counts are stored as duration-1 so the timer compares directly.
    localparam logic [CNT_W-1:0] TC_ON  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] TC_OFF = CNT_W'(OFF_CYCLES - 1);
`ifdef GENIUS_RAPIDO_EN
    localparam int ON_RAP  = ((ON_CYCLES >> 1) < 1) ? 1 : (ON_CYCLES >> 1);
    localparam int OFF_RAP = ((OFF_CYCLES >> 1) < 1) ? 1 : (OFF_CYCLES >> 1);
    localparam logic [CNT_W-1:0] TC_ON_RAP  = CNT_W'(ON_RAP - 1);
    localparam logic [CNT_W-1:0] TC_OFF_RAP = CNT_W'(OFF_RAP - 1);
`endif

    estado_t           estado, estado_prox;
    logic [ADDR_W-1:0] endereco_prox;
    logic [ADDR_W-1:0] limite_reg, limite_prox;
    logic [CNT_W-1:0]  timer, timer_prox;
    logic [CNT_W-1:0]  tc_on, tc_on_prox;
    logic [CNT_W-1:0]  tc_off, tc_off_prox;
    logic [DATA_W-1:0] cor, cor_prox;
    logic [DATA_W-1:0] leds_prox;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado        <= OCIOSO;
            endereco      <= '0;
            limite_reg    <= '0;
            timer         <= '0;
            tc_on         <= TC_ON;
            tc_off        <= TC_OFF;
            cor           <= '0;
            leds_exibicao <= '0;
        end else begin
            estado        <= estado_prox;
            endereco      <= endereco_prox;
            limite_reg    <= limite_prox;
            timer         <= timer_prox;
            tc_on         <= tc_on_prox;
            tc_off        <= tc_off_prox;
            cor           <= cor_prox;
            leds_exibicao <= leds_prox;
        end
    end

    always_comb begin
        estado_prox   = estado;
        endereco_prox = endereco;
        limite_prox   = limite_reg;
        timer_prox    = timer;
        tc_on_prox    = tc_on;
        tc_off_prox   = tc_off;
        cor_prox      = cor;

        case (estado)
            OCIOSO: begin
                if (iniciar && !abortar) begin
                    estado_prox   = CARREGA;
                    limite_prox   = limite;
                    endereco_prox = '0;
                    timer_prox    = '0;
`ifdef GENIUS_RAPIDO_EN
                    tc_on_prox    = rapido ? TC_ON_RAP  : TC_ON;
                    tc_off_prox   = rapido ? TC_OFF_RAP : TC_OFF;
`else
                    tc_on_prox    = TC_ON;
                    tc_off_prox   = TC_OFF;
`endif
                end
            end
            CARREGA: begin
                cor_prox    = dado_memoria;
                timer_prox  = '0;
                estado_prox = ACENDE;
            end
            ACENDE: begin
                if (timer == tc_on) begin
                    timer_prox  = '0;
                    estado_prox = APAGA;
                end else begin
                    timer_prox = timer + 1'b1;
                end
            end
            APAGA: begin
                if (timer == tc_off) begin
                    timer_prox  = '0;
                    // Checking the limit before incrementing means the address never wraps.
                    estado_prox = (endereco == limite_reg) ? FIM : PROXIMO;
                end else begin
                    timer_prox = timer + 1'b1;
                end
            end
            PROXIMO: begin
                endereco_prox = endereco + 1'b1;
                estado_prox   = CARREGA;
            end
            FIM: begin
                estado_prox = OCIOSO;
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase

        if (abortar && (estado != OCIOSO)) begin
            estado_prox   = OCIOSO;
            endereco_prox = '0;
            timer_prox    = '0;
        end

        // LEDs are registered from the next state so they are lit exactly during ACENDE.
        leds_prox = (estado_prox == ACENDE) ? cor_prox : '0;
    end

    assign ocupado   = (estado != OCIOSO);
    assign pronto    = (estado == FIM);
    assign db_estado = estado;

endmodule

// File: tb/tb_genius_controle_exibicao.sv
module tb_genius_controle_exibicao;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       abortar;
    logic       rapido;
    logic [3:0] limite;
    logic [3:0] dado_memoria;
    logic [3:0] endereco;
    logic [3:0] leds_exibicao;
    logic       ocupado;
    logic       pronto;
    logic [2:0] db_estado;

    logic [3:0] mem [16];
    int total = 0;
    int bad   = 0;

    genius_controle_exibicao #(
        .ADDR_W(4), .DATA_W(4), .ON_CYCLES(4), .OFF_CYCLES(2), .CNT_W(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .iniciar(iniciar),
        .abortar(abortar),
`ifdef GENIUS_RAPIDO_EN
        .rapido(rapido),
`endif
        .limite(limite),
        .dado_memoria(dado_memoria),
        .endereco(endereco),
        .leds_exibicao(leds_exibicao),
        .ocupado(ocupado),
        .pronto(pronto),
        .db_estado(db_estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory contents 0x1,0x2,0x4,0x8 repeating; read data follows the address.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'(1 << (i % 4));
    end
    assign dado_memoria = mem[endereco];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string tag, input int st, input logic [3:0] lv, input logic [3:0] av);
        chk({tag, " estado"},   32'(db_estado),     32'(st));
        chk({tag, " leds"},     32'(leds_exibicao), 32'(lv));
        chk({tag, " endereco"}, 32'(endereco),      32'(av));
        chk({tag, " ocupado"},  32'(ocupado),       32'(st != 0));
        chk({tag, " pronto"},   32'(pronto),        32'(st == 5));
    endtask

    // mode 0: plain run; mode 1: iniciar re-pulse and limite change at cycle 10;
    // mode 2: abortar during the second blank period (cycle 14).
    task automatic run(input string name, input int lim, input int on, input int off,
                       input int mode, input logic rap);
        int per, n_cyc, elem, o, st;
        logic [3:0] lv, av;
        per   = on + off + 2;
        n_cyc = (mode == 2) ? 20 : per * (lim + 1) + 1;
        limite  = 4'(lim);
        iniciar = 1'b1;
        rapido  = rap;
        step;
        iniciar = 1'b0;
        rapido  = 1'b0;
        for (int c = 1; c <= n_cyc; c++) begin
            elem = (c - 1) / per;
            o    = (c - 1) % per;
            lv   = 4'h0;
            if (mode == 2 && c >= 15) begin
                st = 0; av = 4'h0;
            end else if (elem > lim) begin
                st = 0; av = 4'(lim);
            end else begin
                av = 4'(elem);
                if (o == 0)              st = 1;
                else if (o <= on)        begin st = 2; lv = 4'(1 << (elem % 4)); end
                else if (o <= on + off)  st = 3;
                else                     st = (elem == lim) ? 5 : 4;
            end
            chk_all($sformatf("%s c%0d", name, c), st, lv, av);
            if (mode == 1 && c == 10) begin iniciar = 1'b1; limite = 4'h0; end
            if (mode == 1 && c == 11) iniciar = 1'b0;
            if (mode == 2 && c == 14) abortar = 1'b1;
            if (mode == 2 && c == 15) abortar = 1'b0;
            if (c < n_cyc) step;
        end
    endtask

    initial begin
        reset   = 1'b0;
        iniciar = 1'b0;
        abortar = 1'b0;
        rapido  = 1'b0;
        limite  = 4'h0;
        #12;
        chk_all("reset", 0, 4'h0, 4'h0);
        reset = 1'b1;
        step;
        chk_all("post_reset", 0, 4'h0, 4'h0);

        // Simultaneous iniciar and abortar in OCIOSO must not start.
        iniciar = 1'b1;
        abortar = 1'b1;
        limite  = 4'h2;
        step;
        iniciar = 1'b0;
        abortar = 1'b0;
        chk_all("ini_abort", 0, 4'h0, 4'h0);

        run("lim2", 2, 4, 2, 0, 1'b0);
        // Started in the first idle cycle after FIM.
        run("lim0", 0, 4, 2, 0, 1'b0);
        run("abort", 2, 4, 2, 2, 1'b0);
        run("replay", 1, 4, 2, 0, 1'b0);
        run("ignore", 2, 4, 2, 1, 1'b0);
        run("lim15", 15, 4, 2, 0, 1'b0);

        // Asynchronous reset in the middle of ACENDE.
        limite  = 4'h2;
        iniciar = 1'b1;
        step;
        iniciar = 1'b0;
        step;
        step;
        chk("mid_acende estado", 32'(db_estado), 32'd2);
        #2;
        reset = 1'b0;
        #1;
        chk_all("async_reset", 0, 4'h0, 4'h0);
        #3;
        reset = 1'b1;
        step;
        chk_all("after_release", 0, 4'h0, 4'h0);

`ifdef GENIUS_RAPIDO_EN
        run("rapido", 2, 2, 1, 0, 1'b1);
        run("normal_again", 0, 4, 2, 0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/genius_controle_exibicao.md
# genius_controle_exibicao

Sequencer that plays the stored Genius colour sequence back to the player before each round. It steps the game memory address from 0 to a latched limit, captures each stored colour and drives it on the display LEDs for a programmable on-time. It then blanks the LEDs for a programmable gap, and signals completion with a one-cycle `pronto` pulse. It sits between the main control unit (issues `iniciar`, waits for `pronto`) and the datapath sequence memory.

## Interface
- `ADDR_W`, 4, memory address width (sequence length up to 2^ADDR_W)
- `DATA_W`, 4, colour word width (one-hot button/LED code)
- `ON_CYCLES`, 500, cycles a colour stays lit (≥1)
- `OFF_CYCLES`, 250, blank cycles after each colour (≥1)
- `CNT_W`, 16, timer width; must hold max(ON_CYCLES, OFF_CYCLES)

- `clock`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `iniciar`  in  1  start request, sampled only in OCIOSO
- `abortar`  in  1  synchronous cancel, any state
- `limite`  in  ADDR_W  index of last element to show, latched at start
- `dado_memoria`  in  DATA_W  memory read data, valid one cycle after `endereco` changes
- `endereco`  out  ADDR_W  memory read address
- `leds_exibicao`  out  DATA_W  colour currently displayed (0 = blank)
- `ocupado`  out  1  high in every state except OCIOSO
- `pronto`  out  1  one-cycle pulse in FIM
- `db_estado`  out  3  current state code

## Operation
- States and codes:
  - OCIOSO=0
  - CARREGA=1
  - ACENDE=2
  - APAGA=3
  - PROXIMO=4
  - FIM=5
- OCIOSO:
  - `iniciar`=1 and `abortar`=0 → CARREGA; latch `limite`; `endereco`←0; timer←0.
- CARREGA (1 cycle):
  - register `dado_memoria` into colour register → ACENDE.
- ACENDE:
  - `leds_exibicao`=colour register; timer counts 0..ON_CYCLES-1.
  - At terminal count → APAGA, timer←0.
- APAGA:
  - `leds_exibicao`=0; timer counts 0..OFF_CYCLES-1.
  - At terminal count: `endereco`==latched limit → FIM, else → PROXIMO.
- PROXIMO (1 cycle):
  - `endereco`←`endereco`+1 → CARREGA.
- FIM (1 cycle):
  - `pronto`=1 → OCIOSO; `endereco` holds last value until the next start.
- `abortar`=1 in any state except OCIOSO:
  - next state OCIOSO; `leds_exibicao` 0 next cycle; no `pronto`; `endereco`←0.
- Simultaneous `iniciar` and `abortar` in OCIOSO: stay OCIOSO.
- `iniciar` while `ocupado`: ignored (no restart, no queuing).
- `limite` changes after start: ignored.
- `limite`=0: exactly one element shown.
- `limite`=2^ADDR_W-1: all addresses shown, no wrap; increment never occurs past the limit.
- `leds_exibicao` is registered (glitch-free); 0 in every state except ACENDE.

## Timing
- Reset values:
  - state OCIOSO
  - `endereco`=0, `leds_exibicao`=0, `ocupado`=0, `pronto`=0, `db_estado`=0
  - timer and colour register 0
- `iniciar` sampled at edge k → CARREGA during cycle k+1; `ocupado` rises in cycle k+1.
- Per element: 1 (CARREGA) + ON_CYCLES + OFF_CYCLES + 1 (PROXIMO, or FIM on the last element) cycles.
- N = limite+1 elements → `pronto` in cycle k + N·(ON_CYCLES+OFF_CYCLES+2).
- `ocupado` falls the cycle after `pronto`.
- A new `iniciar` is accepted in the first OCIOSO cycle after FIM.
- `abortar` at edge j → OCIOSO and outputs cleared in cycle j+1.

## Configuration
- `GENIUS_RAPIDO_EN` defined:
  - adds input port `rapido` (1 bit), sampled together with `iniciar`.
  - If `rapido`=1, on and gap durations are ON_CYCLES>>1 and OFF_CYCLES>>1, each clamped to a minimum of 1, for the whole playback.
- Not defined:
  - no `rapido` port; durations always ON_CYCLES and OFF_CYCLES.

## Test plan
Bench parameters: ON_CYCLES=4, OFF_CYCLES=2, memory {0x1, 0x2, 0x4, 0x8, …}.
- Reset asserted low mid-ACENDE → all outputs 0 immediately (asynchronous); state OCIOSO after release.
- `limite`=2, `iniciar` at edge 0:
  - `leds_exibicao` = 1,1,1,1,0,0, then 2×4 and 0×2, then 4×4 and 0×2.
  - `endereco` 0→1→2.
  - `ocupado` high cycles 1–24; `pronto` only in cycle 24.
- `limite`=0 → single lit 0x1 for 4 cycles; `pronto` in cycle 8; `endereco` stays 0.
- `abortar` during second APAGA → OCIOSO next cycle, LEDs 0, no `pronto`; a fresh `iniciar` replays from address 0.
- `iniciar` pulsed again in cycle 10 of a running playback and `limite` changed mid-run → both ignored; timing identical to the `limite`=2 case.
- With `GENIUS_RAPIDO_EN`, `rapido`=1, `limite`=2 → 2 lit / 1 blank per element; `pronto` in cycle 15.
